// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared ALU codes, alu_op/funct constants and EX control bundle
//
// Purpose : constants shared by the ID/EX front end and the downstream ALU.
//           Holds the 4-bit ALU operation codes, the 2-bit alu_op classes
//           produced by the main decoder, the R-type funct values, the
//           hard-wired zero register index and the packed EX control bundle.
// Ports   : none (package).

package id_ex_stage_pkg;

  // 4-bit ALU operation codes understood by the 32-bit ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Operation class coming out of the main decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // Register 0 is hard-wired to zero and never a forwarding source
  localparam int REG_ZERO = 0;

  // Control fields carried through the EX register
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_control;
  } ex_ctrl_t;

  // A bubble is a non-writing, non-memory no-op that still presents ADD
  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:       1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    alu_src:     1'b0,
    alu_control: ALU_ADD
  };

endpackage

// File: rtl/id_ex_stage_alu_ctrl.sv
// rtl/id_ex_stage_alu_ctrl.sv - combinational alu_op/funct to ALU control decoder
//
// Purpose : maps the decoder's alu_op class and the R-type funct field to
//           the 4-bit ALU operation code. Used on the ID side so that the
//           code is registered into EX together with the operands.
// Ports   : alu_op      in  2  operation class (00 add, 01 sub, 10 funct, 11 or)
//           funct       in  6  R-type funct field
//           alu_control out 4  ALU operation code

module alu_ctrl
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_OR:  alu_control = ALU_OR;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          FUNCT_NOR: alu_control = ALU_NOR;
          // Unimplemented functs degrade to ADD rather than an undefined op
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use detection
//
// Purpose : registers decoded ID fields into EX, registers the ALU control
//           code, resolves rs/rt forwarding from EX/MEM and MEM/WB and drives
//           the ALU operands. Requests a one-cycle upstream hold on load-use.
// Ports   : clk, rst_n                     clock, async active-low reset
//           stall, flush                   hold EX / load a bubble
//           id_*                           decoded ID-stage instruction
//           exmem_reg_write/rd/result      EX/MEM forwarding source
//           memwb_reg_write/rd/result      MEM/WB forwarding source
//           alu_a, alu_b, alu_control      ALU operands and operation
//           ex_store_data                  forwarded rt for stores
//           ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write,
//           ex_mem_to_reg, ex_valid        registered downstream fields
//           load_use                       combinational hazard request

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_reg_dst,
  input  logic          id_alu_src,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_control,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_write_reg,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_valid,
  output logic          load_use
);

  localparam logic [RW-1:0] ZERO_REG = RW'(REG_ZERO);

  // ID-side decode
  logic [3:0] id_alu_control;
  ex_ctrl_t   id_ctrl;

  alu_ctrl u_alu_ctrl (
    .alu_op      (id_alu_op),
    .funct       (id_funct),
    .alu_control (id_alu_control)
  );

  always_comb begin
    id_ctrl             = BUBBLE_CTRL;
    id_ctrl.valid       = id_valid;
    id_ctrl.reg_write   = id_reg_write;
    id_ctrl.mem_read    = id_mem_read;
    id_ctrl.mem_write   = id_mem_write;
    id_ctrl.mem_to_reg  = id_mem_to_reg;
    id_ctrl.alu_src     = id_alu_src;
    id_ctrl.alu_control = id_alu_control;
  end

  // EX register
  ex_ctrl_t      ex_ctrl;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [RW-1:0] ex_dst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl    <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
    end else if (!stall) begin
      if (flush || load_use) begin
        ex_ctrl    <= BUBBLE_CTRL;
        ex_rs_data <= '0;
        ex_rt_data <= '0;
        ex_imm     <= '0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_dst     <= '0;
      end else begin
        ex_ctrl    <= id_ctrl;
        ex_rs_data <= id_rs_data;
        ex_rt_data <= id_rt_data;
        ex_imm     <= id_imm;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_dst     <= id_reg_dst ? id_rd : id_rt;
      end
    end
  end

  // Forwarding: the younger EX/MEM result takes precedence over MEM/WB
  logic          exmem_ok;
  logic          memwb_ok;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  assign exmem_ok = exmem_reg_write && (exmem_rd != ZERO_REG);
  assign memwb_ok = memwb_reg_write && (memwb_rd != ZERO_REG);

  always_comb begin
    fwd_rs = ex_rs_data;
    if (exmem_ok && (exmem_rd == ex_rs))
      fwd_rs = exmem_result;
    else if (memwb_ok && (memwb_rd == ex_rs))
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = ex_rt_data;
    if (exmem_ok && (exmem_rd == ex_rt))
      fwd_rt = exmem_result;
    else if (memwb_ok && (memwb_rd == ex_rt))
      fwd_rt = memwb_result;
  end

  // A load in EX cannot forward its data to the instruction now in ID
  assign load_use = ex_ctrl.valid && ex_ctrl.mem_read && id_valid &&
                    (ex_dst != ZERO_REG) &&
                    ((ex_dst == id_rs) || (ex_dst == id_rt));

  assign alu_a         = fwd_rs;
  assign alu_b         = ex_ctrl.alu_src ? ex_imm : fwd_rt;
  assign alu_control   = ex_ctrl.alu_control;
  assign ex_store_data = fwd_rt;
  assign ex_write_reg  = ex_dst;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_valid      = ex_ctrl.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage

module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_reg_dst;
  logic        id_alu_src;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_valid;
  logic        load_use;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_mem_to_reg   (id_mem_to_reg),
    .id_reg_dst      (id_reg_dst),
    .id_alu_src      (id_alu_src),
    .id_alu_op       (id_alu_op),
    .id_funct        (id_funct),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_control     (alu_control),
    .ex_store_data   (ex_store_data),
    .ex_write_reg    (ex_write_reg),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_valid        (ex_valid),
    .load_use        (load_use)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // flags = {valid, reg_write, mem_read, mem_write, mem_to_reg}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  ctl;
    logic [4:0]  wr;
    logic [4:0]  flags;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                            input logic [3:0] ctl, input logic [4:0] wr, input logic [4:0] flags);
    exp_t e;
    e.a = a; e.b = b; e.sd = sd; e.ctl = ctl; e.wr = wr; e.flags = flags;
    exp_q.push_back(e);
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_alu_a"}, alu_a, e.a);
      check({name, "_alu_b"}, alu_b, e.b);
      check({name, "_store"}, ex_store_data, e.sd);
      check({name, "_ctl"}, {28'd0, alu_control}, {28'd0, e.ctl});
      check({name, "_wreg"}, {27'd0, ex_write_reg}, {27'd0, e.wr});
      check({name, "_flags"},
            {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {27'd0, e.flags});
    end
  endtask

  // ctl6 = {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src}
  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] ctl6,
                        input logic [1:0] op, input logic [5:0] fn);
    id_valid      = v;
    id_rs_data    = rsd;
    id_rt_data    = rtd;
    id_imm        = imm;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_reg_write  = ctl6[5];
    id_mem_read   = ctl6[4];
    id_mem_write  = ctl6[3];
    id_mem_to_reg = ctl6[2];
    id_reg_dst    = ctl6[1];
    id_alu_src    = ctl6[0];
    id_alu_op     = op;
    id_funct      = fn;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_id(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 6'd0);
    clear_fwd();
    repeat (2) tick();

    // Reset state
    expect_out(32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 5'b00000);
    compare_out("rst");
    check("rst_load_use", {31'd0, load_use}, 32'd0);
    rst_n = 1'b1;

    // Plain R-type add, then async reset mid-cycle with inputs still valid
    set_id(1'b1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 6'b100010, 2'b10, 6'b100000);
    expect_out(32'd5, 32'd7, 32'd7, 4'b0010, 5'd3, 5'b11000);
    tick();
    compare_out("load");
    #3 rst_n = 1'b0;
    expect_out(32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 5'b00000);
    #1 compare_out("async_rst");
    #1 rst_n = 1'b1;
    expect_out(32'd5, 32'd7, 32'd7, 4'b0010, 5'd3, 5'b11000);
    tick();
    compare_out("post_rst");

    // ALU control decode
    set_id(1'b1, 32'h0F0F0000, 32'h00FF00FF, 32'd0, 5'd9, 5'd10, 5'd11, 6'b100010, 2'b10, 6'b100111);
    expect_out(32'h0F0F0000, 32'h00FF00FF, 32'h00FF00FF, 4'b1100, 5'd11, 5'b11000);
    tick();
    compare_out("nor");
    id_funct = 6'b111111;
    expect_out(32'h0F0F0000, 32'h00FF00FF, 32'h00FF00FF, 4'b0010, 5'd11, 5'b11000);
    tick();
    compare_out("funct_unknown");
    id_funct = 6'b101010;
    expect_out(32'h0F0F0000, 32'h00FF00FF, 32'h00FF00FF, 4'b0111, 5'd11, 5'b11000);
    tick();
    compare_out("slt");
    set_id(1'b1, 32'd40, 32'd30, 32'd0, 5'd1, 5'd2, 5'd7, 6'b000000, 2'b01, 6'd0);
    expect_out(32'd40, 32'd30, 32'd30, 4'b0110, 5'd2, 5'b10000);
    tick();
    compare_out("branch_sub");
    set_id(1'b1, 32'h0F00, 32'h999, 32'h00F0, 5'd3, 5'd4, 5'd9, 6'b100001, 2'b11, 6'd0);
    expect_out(32'h0F00, 32'h00F0, 32'h999, 4'b0001, 5'd4, 5'b11000);
    tick();
    compare_out("ori");

    // Forwarding priority
    set_id(1'b1, 32'hAAAA, 32'hBBBB, 32'd0, 5'd5, 5'd5, 5'd6, 6'b100010, 2'b10, 6'b100000);
    expect_out(32'hAAAA, 32'hBBBB, 32'hBBBB, 4'b0010, 5'd6, 5'b11000);
    tick();
    compare_out("fwd_load");
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h22;
    expect_out(32'h11, 32'h11, 32'h11, 4'b0010, 5'd6, 5'b11000);
    #1 compare_out("fwd_both");
    exmem_reg_write = 1'b0;
    expect_out(32'h22, 32'h22, 32'h22, 4'b0010, 5'd6, 5'b11000);
    #1 compare_out("fwd_memwb");
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    expect_out(32'hAAAA, 32'hBBBB, 32'hBBBB, 4'b0010, 5'd6, 5'b11000);
    #1 compare_out("fwd_r0");
    clear_fwd();

    // Immediate operand with forwarded store data
    set_id(1'b1, 32'h100, 32'h1, 32'hFFFFFFFC, 5'd7, 5'd6, 5'd0, 6'b001001, 2'b00, 6'd0);
    expect_out(32'h100, 32'hFFFFFFFC, 32'h1, 4'b0010, 5'd6, 5'b10010);
    tick();
    compare_out("sw_load");
    exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_result = 32'hABCD;
    expect_out(32'h100, 32'hFFFFFFFC, 32'hABCD, 4'b0010, 5'd6, 5'b10010);
    #1 compare_out("sw_fwd");
    clear_fwd();

    // Load-use on rs: one bubble, then the held add enters EX
    set_id(1'b1, 32'h1000, 32'd0, 32'd4, 5'd1, 5'd8, 5'd0, 6'b110101, 2'b00, 6'd0);
    expect_out(32'h1000, 32'd4, 32'd0, 4'b0010, 5'd8, 5'b11101);
    tick();
    compare_out("lw");
    set_id(1'b1, 32'd3, 32'd4, 32'd0, 5'd8, 5'd2, 5'd9, 6'b100010, 2'b10, 6'b100000);
    #1 check("lu_hit", {31'd0, load_use}, 32'd1);
    expect_out(32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 5'b00000);
    tick();
    compare_out("lu_bubble");
    check("lu_clear", {31'd0, load_use}, 32'd0);
    expect_out(32'd3, 32'd4, 32'd4, 4'b0010, 5'd9, 5'b11000);
    tick();
    compare_out("lu_resume");

    // Stall and flush together hold; flush alone bubbles
    set_id(1'b1, 32'h77, 32'h66, 32'd0, 5'd13, 5'd14, 5'd15, 6'b100010, 2'b01, 6'd0);
    stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_out(32'd3, 32'd4, 32'd4, 4'b0010, 5'd9, 5'b11000);
      tick();
      compare_out("stall_flush");
    end
    stall = 1'b0;
    expect_out(32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 5'b00000);
    tick();
    compare_out("flush_bubble");
    flush = 1'b0;
    expect_out(32'h77, 32'h66, 32'h66, 4'b0110, 5'd15, 5'b11000);
    tick();
    compare_out("after_flush");

    // Load-use on rt while stalled: request stays up, EX holds the load
    set_id(1'b1, 32'h2000, 32'd0, 32'd8, 5'd1, 5'd12, 5'd0, 6'b110101, 2'b00, 6'd0);
    expect_out(32'h2000, 32'd8, 32'd0, 4'b0010, 5'd12, 5'b11101);
    tick();
    compare_out("lw2");
    set_id(1'b1, 32'd5, 32'd6, 32'd0, 5'd3, 5'd12, 5'd4, 6'b100010, 2'b10, 6'b100010);
    stall = 1'b1;
    #1 check("lu_stall", {31'd0, load_use}, 32'd1);
    expect_out(32'h2000, 32'd8, 32'd0, 4'b0010, 5'd12, 5'b11101);
    tick();
    compare_out("lu_stall_hold");
    check("lu_stall_still", {31'd0, load_use}, 32'd1);
    stall = 1'b0;
    expect_out(32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 5'b00000);
    tick();
    compare_out("lu_stall_bubble");
    expect_out(32'd5, 32'd6, 32'd6, 4'b0110, 5'd4, 5'b11000);
    tick();
    compare_out("lu_stall_resume");

    // Reset during a stall discards the held state
    stall = 1'b1;
    #2 rst_n = 1'b0;
    expect_out(32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 5'b00000);
    #1 compare_out("rst_stall");
    rst_n = 1'b1;
    expect_out(32'd0, 32'd0, 32'd0, 4'b0000, 5'd0, 5'b00000);
    tick();
    compare_out("rst_stall_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand front end, sitting directly upstream of the 32-bit ALU.
- Registers decoded ID-stage fields, derives the 4-bit ALU control code, and resolves operand forwarding from EX/MEM and MEM/WB.
- Drives ALU operand A, operand B and alu_control, and forwards control/destination fields downstream.
- Detects load-use hazards and inserts bubbles on flush.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the EX register (downstream backpressure).
- flush  in  1  replace the incoming instruction with a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  DW  register-file read data.
- id_imm  in  DW  sign/zero-extended immediate.
- id_rs, id_rt, id_rd  in  RW  register addresses.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_dst, id_alu_src  in  1 each  decoded controls.
- id_alu_op  in  2  00=add, 01=sub, 10=R-type(funct), 11=or.
- id_funct  in  6  R-type funct field.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_rd  in  RW  EX/MEM destination.
- exmem_result  in  DW  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_rd  in  RW  MEM/WB destination.
- memwb_result  in  DW  MEM/WB writeback data.
- alu_a, alu_b  out  DW  ALU operands.
- alu_control  out  4  ALU operation code.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_write_reg  out  RW  selected destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid  out  1 each  registered controls.
- load_use  out  1  combinational hazard request for upstream to hold IF/ID.

Behaviour:
- Reset (async, rst_n=0): all EX registers clear to 0; every output reads 0.
- Register update priority at each rising edge: stall (hold all) > (flush | load_use) (load bubble) > normal load.
- Bubble: valid, reg_write, mem_read, mem_write, mem_to_reg = 0; data/address fields = 0; alu_control = 0010.
- Latency: one cycle from ID inputs to registered EX fields; forwarding and operand muxes are combinational from EX registers.
- ex_write_reg is resolved at load: id_reg_dst ? id_rd : id_rt.
- alu_control is decoded in ID and registered:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100, any other -> 0010.
- Forwarding, for operand rs (rt identical):
  - If exmem_reg_write and exmem_rd!=0 and exmem_rd==ex_rs: use exmem_result.
  - Else if memwb_reg_write and memwb_rd!=0 and memwb_rd==ex_rs: use memwb_result.
  - Else: registered rs data.
  - EX/MEM wins when both match; register 0 is never forwarded.
- alu_a = fwd_rs; alu_b = ex_alu_src ? ex_imm : fwd_rt; ex_store_data = fwd_rt always.
- load_use = ex_valid & ex_mem_read & id_valid & ex_write_reg!=0 & (ex_write_reg==id_rs | ex_write_reg==id_rt). It is asserted even while stall=1, but stall still holds the register.
- A bubble clears ex_mem_read, so load_use self-clears after one cycle: one-cycle stall per load-use pair.
- Simultaneous stall and flush: hold wins; the flush must be re-asserted by its source.
- Reset mid-stall: registers clear immediately; no held state survives.

Decomposition:
- Shared include alu_defs.vh: ALU codes AND/OR/ADD/SUB/SLT/NOR, alu_op codes, funct constants, REG_ZERO. Used by this block and the ALU.
- One sub-module, alu_ctrl: combinational alu_op/funct to 4-bit code decoder, instanced on the ID side.

Test Plan:
- Reset: rst_n low mid-cycle with valid data on inputs -> all outputs 0 immediately; after release and no input change, next edge loads inputs.
- R-type decode: alu_op=10, funct=100111, rs_data=0x0F0F0000, rt_data=0x00FF00FF, no forwarding -> next cycle alu_control=1100, alu_a=0x0F0F0000, alu_b=0x00FF00FF; unknown funct 111111 -> 0010.
- Forwarding priority: ex_rs=ex_rt=5, exmem_rd=5 result 0x11, memwb_rd=5 result 0x22, both write -> alu_a=alu_b=0x11; drop exmem_reg_write -> 0x22; rd=0 on both -> registered data.
- Immediate/store: alu_src=1, imm=0xFFFFFFFC, forwarded rt=0xABCD -> alu_b=0xFFFFFFFC, ex_store_data=0xABCD.
- Load-use: lw to $8 in EX, ID add reads rs=$8 -> load_use=1; next edge bubble (ex_valid=0, ex_reg_write=0); load_use drops; following edge loads the held add.
- Stall vs flush: stall=1 and flush=1 together for 2 cycles -> outputs unchanged; flush alone -> bubble loaded, alu_control=0010.
